// File: rtl/median_pkg.sv
// Shared types and schedule helpers for the median filter (controller and datapath top).
package median_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DONE
    } state_e;

    localparam int unsigned DEFAULT_NUMBER = 9;

    // Number of max extractions needed before the median sits at the output.
    function automatic int unsigned num_passes(input int unsigned number);
        return (number - 1) / 2;
    endfunction

    // Cycles from the first accepted pixel to the DSO cycle, inclusive.
    function automatic int unsigned total_cycles(input int unsigned number);
        return number + num_passes(number) * number + (number - 1 - num_passes(number)) + 1;
    endfunction

    localparam int unsigned DEFAULT_P     = num_passes(DEFAULT_NUMBER);
    localparam int unsigned DEFAULT_TOTAL = total_cycles(DEFAULT_NUMBER);

endpackage

// File: rtl/median_ctrl.sv
// Sequencer for the MED compare-exchange datapath: load, P max-extraction passes, median flag.
// Optional sticky overrun output OVR when MEDIAN_CTRL_OVR_EN is defined.
module median_ctrl
    import median_pkg::*;
#(
    parameter int unsigned NUMBER = DEFAULT_NUMBER
) (
    input  logic CLK,
    input  logic nRST,
    input  logic DSI_IN,
    output logic DSI,
    output logic BYP,
    output logic BUSY,
    output logic DSO
`ifdef MEDIAN_CTRL_OVR_EN
    ,
    output logic OVR
`endif
);

    localparam int unsigned CNT_W = $clog2(NUMBER + 1);
    localparam int unsigned P     = num_passes(NUMBER);

    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(NUMBER - 1);
    localparam logic [CNT_W-1:0] CMP_LAST   = CNT_W'(NUMBER - 2);
    localparam logic [CNT_W-1:0] FINAL_LAST = CNT_W'(NUMBER - 2 - P);
    localparam logic [CNT_W-1:0] PASS_LAST  = CNT_W'(P);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic             sort_byp;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            step_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                // The accepting cycle already loads pixel 0, so LOAD starts at step 1.
                if (DSI_IN) begin
                    state_d = LOAD;
                    step_d  = CNT_W'(1);
                    pass_d  = '0;
                end
            end
            LOAD: begin
                if (step_q == STEP_LAST) begin
                    state_d = SORT;
                    step_d  = '0;
                    pass_d  = '0;
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            SORT: begin
                if (pass_q == PASS_LAST) begin
                    if (step_q == FINAL_LAST) begin
                        state_d = DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    pass_d = pass_q + CNT_W'(1);
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
                pass_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                pass_d  = '0;
            end
        endcase
    end

    // Pass p compares on steps 0..NUMBER-2-p then shifts; the final pass only compares.
    always_comb begin
        sort_byp = 1'b0;
        if (pass_q != PASS_LAST) begin
            sort_byp = (step_q > (CMP_LAST - pass_q));
        end
    end

    always_comb begin
        DSI  = 1'b0;
        BYP  = 1'b1;
        BUSY = 1'b1;
        DSO  = 1'b0;
        case (state_q)
            IDLE: begin
                // Accepting cycle counts as part of the burst.
                DSI  = DSI_IN;
                BUSY = DSI_IN;
            end
            LOAD: DSI = 1'b1;
            SORT: BYP = sort_byp;
            DONE: DSO = 1'b1;
            default: BUSY = 1'b0;
        endcase
    end

`ifdef MEDIAN_CTRL_OVR_EN
    logic ovr_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovr_q <= 1'b0;
        end else if (DSI_IN && (state_q == SORT || state_q == DONE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign OVR = ovr_q;
`endif

endmodule

// File: tb/tb_median_ctrl.sv
// Self-checking bench for median_ctrl (NUMBER=9): schedule, timing, overrun, reset, back-to-back.
module tb_median_ctrl;

    localparam int NUMBER = 9;
    localparam int LAT    = 49;
    localparam int NSORT  = 40;

    logic CLK = 1'b0;
    logic nRST;
    logic DSI_IN;
    logic DSI, BYP, BUSY, DSO;
`ifdef MEDIAN_CTRL_OVR_EN
    logic OVR;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int gcyc        = 0;
    int sb[$];
    bit exp_byp[NSORT];
    bit ovr_exp = 1'b0;

    median_ctrl #(.NUMBER(NUMBER)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .DSI_IN(DSI_IN),
        .DSI   (DSI),
        .BYP   (BYP),
        .BUSY  (BUSY),
        .DSO   (DSO)
`ifdef MEDIAN_CTRL_OVR_EN
        ,
        .OVR   (OVR)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) gcyc <= gcyc + 1;

    // Passes p=0..3: (8-p) compares then (p+1) shifts; final pass 4 compares.
    task automatic build_byp();
        int idx = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8 - p; k++) begin exp_byp[idx] = 1'b0; idx++; end
            for (int k = 0; k < p + 1; k++) begin exp_byp[idx] = 1'b1; idx++; end
        end
        for (int k = 0; k < 4; k++) begin exp_byp[idx] = 1'b0; idx++; end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Caller arrives just after a rising edge with the DUT idle; returns in relative cycle 50.
    task automatic run_burst(input int pulse_at, input string tag, output int dso_at);
        int e;
        bit xd, xb;
        dso_at = -1;
        DSI_IN = 1'b1;
        sb.push_back(gcyc + LAT);
        for (int r = 0; r <= LAT; r++) begin
            @(negedge CLK);
            xd = (r < NUMBER);
            xb = (r >= NUMBER && r < LAT) ? exp_byp[r - NUMBER] : 1'b1;
            vectors++;
            if (DSI !== xd) begin
                miscompares++;
                $display("FAIL %s dsi r=%0d got %b expected %b", tag, r, DSI, xd);
            end
            vectors++;
            if (BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy r=%0d got %b expected 1", tag, r, BUSY);
            end
            vectors++;
            if (BYP !== xb) begin
                miscompares++;
                $display("FAIL %s byp r=%0d got %b expected %b", tag, r, BYP, xb);
            end
            if (DSO === 1'b1) begin
                dso_at = gcyc;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s dso_unexpected cycle=%0d got 1 expected 0", tag, gcyc);
                end else begin
                    e = sb.pop_front();
                    if (e != gcyc) begin
                        miscompares++;
                        $display("FAIL %s dso_time got cycle %0d expected cycle %0d",
                                 tag, gcyc, e);
                    end
                end
            end else if (sb.size() > 0 && sb[0] == gcyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s dso_missing cycle=%0d got 0 expected 1", tag, gcyc);
                void'(sb.pop_front());
            end
`ifdef MEDIAN_CTRL_OVR_EN
            if (pulse_at >= NUMBER && r > pulse_at) ovr_exp = 1'b1;
            vectors++;
            if (OVR !== ovr_exp) begin
                miscompares++;
                $display("FAIL %s ovr r=%0d got %b expected %b", tag, r, OVR, ovr_exp);
            end
`endif
            next_cycle();
            DSI_IN = (r + 1 < NUMBER) || (r + 1 == pulse_at);
        end
    endtask

    task automatic check_idle(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            vectors++;
            if ({DSI, BYP, BUSY, DSO} !== 4'b0100) begin
                miscompares++;
                $display("FAIL %s idle i=%0d got dsi/byp/busy/dso=%b expected 0100",
                         tag, i, {DSI, BYP, BUSY, DSO});
            end
            next_cycle();
        end
    endtask

    task automatic test_reset();
        nRST   = 1'b0;
        DSI_IN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if ({DSI, BYP, BUSY, DSO} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_outputs got dsi/byp/busy/dso=%b expected 0100",
                     {DSI, BYP, BUSY, DSO});
        end
`ifdef MEDIAN_CTRL_OVR_EN
        vectors++;
        if (OVR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovr got %b expected 0", OVR);
        end
`endif
        next_cycle();
        nRST = 1'b1;
        check_idle("idle_after_reset", 4);
    endtask

    task automatic test_single_burst();
        int d;
        run_burst(-1, "burst", d);
        check_idle("burst_end", 3);
    endtask

    task automatic test_overrun_sort();
        int d;
        run_burst(20, "ovr_sort", d);
        check_idle("ovr_sort_end", 2);
    endtask

    task automatic test_overrun_done();
        int d;
        run_burst(LAT, "ovr_done", d);
        check_idle("ovr_done_not_accepted", 3);
    endtask

    task automatic test_mid_reset();
        int d;
        DSI_IN = 1'b1;
        for (int r = 0; r < 30; r++) begin
            next_cycle();
            DSI_IN = (r + 1 < NUMBER);
        end
        nRST = 1'b0;
        #1;
        vectors++;
        if ({DSI, BYP, BUSY, DSO} !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got dsi/byp/busy/dso=%b expected 0100",
                     {DSI, BYP, BUSY, DSO});
        end
        ovr_exp = 1'b0;
`ifdef MEDIAN_CTRL_OVR_EN
        vectors++;
        if (OVR !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ovr got %b expected 0", OVR);
        end
`endif
        sb.delete();
        next_cycle();
        next_cycle();
        nRST = 1'b1;
        check_idle("mid_reset_idle", 2);
        run_burst(-1, "after_reset", d);
        check_idle("after_reset_end", 1);
    endtask

    task automatic test_back_to_back();
        int d0, d1, d2;
        run_burst(-1, "b2b0", d0);
        run_burst(-1, "b2b1", d1);
        run_burst(-1, "b2b2", d2);
        vectors++;
        if (d1 - d0 != 50) begin
            miscompares++;
            $display("FAIL b2b_spacing01 got %0d expected 50", d1 - d0);
        end
        vectors++;
        if (d2 - d1 != 50) begin
            miscompares++;
            $display("FAIL b2b_spacing12 got %0d expected 50", d2 - d1);
        end
        check_idle("b2b_end", 2);
    endtask

    initial begin
        build_byp();
        test_reset();
        test_single_burst();
        test_overrun_sort();
        test_overrun_done();
        test_mid_reset();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
